// File: rtl/tmul_pkg.sv
// -----------------------------------------------------------------------------
// tmul_pkg
// Shared defaults and helper types for the K x N tile multiply-accumulate
// pipeline (tmul_kxn_pipe) and its per-stage datapath (tmul_fma_stage).
//   TMUL_AW : operand width (unsigned)
//   TMUL_K  : reduction depth = number of FMA stages
//   TMUL_N  : output column count
//   TMUL_CW : accumulator / result column width
// -----------------------------------------------------------------------------
package tmul_pkg;

   localparam int TMUL_AW = 32;
   localparam int TMUL_K  = 8;
   localparam int TMUL_N  = 8;
   localparam int TMUL_CW = 64;

   // One element of the row vector a[k].
   typedef logic [TMUL_AW-1:0]        tmul_operand_t;
   // One matrix row b[k]; column n sits at bits [n*AW +: AW].
   typedef logic [TMUL_N*TMUL_AW-1:0] tmul_brow_t;
   // One accumulator / result column.
   typedef logic [TMUL_CW-1:0]        tmul_col_t;

endpackage

// File: rtl/tmul_fma_stage.sv
// -----------------------------------------------------------------------------
// tmul_fma_stage
// One registered multiply-add step of the tile pipeline. For every column n it
// adds the zero-extended 2*AW-bit product a_i * b_i[n] to the incoming column
// sum modulo 2^CW and ORs the carry-out into the running overflow flag.
// Ports:
//   clk, rst : clock, synchronous active-high reset (clears valid/sum/ovf)
//   en_i     : advance enable; when low all registers hold
//   vld_i    : incoming tile is valid
//   sum_i    : incoming column sums       ovf_i : incoming overflow flags
//   a_i      : a[k] for this stage        b_i   : b[k] row for this stage
//   vld_o, sum_o, ovf_o : registered stage contents
// -----------------------------------------------------------------------------
module tmul_fma_stage
   import tmul_pkg::*;
#(
   parameter int AW = TMUL_AW,
   parameter int N  = TMUL_N,
   parameter int CW = TMUL_CW
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en_i,
   input  logic                  vld_i,
   input  logic [N-1:0][CW-1:0]  sum_i,
   input  logic [N-1:0]          ovf_i,
   input  logic [AW-1:0]         a_i,
   input  logic [N*AW-1:0]       b_i,
   output logic                  vld_o,
   output logic [N-1:0][CW-1:0]  sum_o,
   output logic [N-1:0]          ovf_o
);

   logic [N-1:0][2*AW-1:0] prod_w;
   logic [N-1:0][CW:0]     wide_w;   // one extra bit captures the carry-out
   logic [N-1:0][CW-1:0]   sum_d;
   logic [N-1:0]           ovf_d;

   always_comb begin
      prod_w = '0;
      wide_w = '0;
      sum_d  = '0;
      ovf_d  = '0;
      for (int n = 0; n < N; n++) begin
         prod_w[n] = (2*AW)'(a_i) * (2*AW)'(b_i[n*AW +: AW]);
         wide_w[n] = {1'b0, sum_i[n]} + {{(CW+1-2*AW){1'b0}}, prod_w[n]};
         sum_d[n]  = wide_w[n][CW-1:0];
         ovf_d[n]  = ovf_i[n] | wide_w[n][CW];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_o <= 1'b0;
         sum_o <= '0;
         ovf_o <= '0;
      end else if (en_i) begin
         vld_o <= vld_i;
         sum_o <= sum_d;
         ovf_o <= ovf_d;
      end
   end

endmodule

// File: rtl/tmul_kxn_pipe.sv
// -----------------------------------------------------------------------------
// tmul_kxn_pipe
// K-stage pipelined tile multiply-accumulate: c[n] = seed[n] + sum_k a[k]*b[k][n]
// with seed = acc_en ? c_in : 0. Stage k adds product k; the tile's remaining
// operand rows travel with it so the caller only holds inputs for one cycle.
// The last stage register is the output register (c, ovf, out_valid).
//
// Handshake: a tile is accepted on any cycle with in_valid && in_ready; a result
// is taken on any cycle with out_valid && out_ready. stall = out_valid &&
// !out_ready freezes the whole pipe, and in_ready = !stall (forced low while rst
// is high). Accept and take in the same cycle both proceed with no bubble.
//
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : input tile handshake
//   a [K][AW]            : row vector         b [K][N*AW] : matrix rows
//   c_in [N][CW], acc_en : accumulate seed and its enable
//   out_valid / out_ready: result handshake
//   c [N][CW], ovf [N]   : result columns and per-column carry-out flags
//   busy                 : any stage holds a valid tile
// -----------------------------------------------------------------------------
module tmul_kxn_pipe
   import tmul_pkg::*;
#(
   parameter int AW = TMUL_AW,
   parameter int K  = TMUL_K,
   parameter int N  = TMUL_N,
   parameter int CW = TMUL_CW
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [K-1:0][AW-1:0]  a,
   input  logic [K-1:0][N*AW-1:0] b,
   input  logic [N-1:0][CW-1:0]  c_in,
   input  logic                  acc_en,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [N-1:0][CW-1:0]  c,
   output logic [N-1:0]          ovf,
   output logic                  busy
);

   logic                          stall;
   logic                          adv;
   logic                          accept;
   logic [N-1:0][CW-1:0]          seed;
   logic [K-1:0]                  vld_w;
   logic [K-1:0][N-1:0][CW-1:0]   sum_w;
   logic [K-1:0][N-1:0]           ovf_w;

   assign stall    = out_valid && !out_ready;
   assign adv      = !stall;
   assign in_ready = !rst && !stall;
   assign accept   = in_valid && in_ready;

   always_comb begin
      seed = '0;
      for (int n = 0; n < N; n++) begin
         seed[n] = acc_en ? c_in[n] : '0;
      end
   end

   for (genvar k = 0; k < K; k++) begin : g_stage
      logic                 st_vld;
      logic [N-1:0][CW-1:0] st_sum;
      logic [N-1:0]         st_ovf;
      logic [AW-1:0]        st_a;
      logic [N*AW-1:0]      st_b;

      if (k == 0) begin : g_head
         // Stage 0 captures the tile and performs the first multiply-add.
         assign st_vld = accept;
         assign st_sum = seed;
         assign st_ovf = '0;
         assign st_a   = a[0];
         assign st_b   = b[0];
      end else begin : g_body
         // Row k is the lowest row of the carry held alongside stage k-1.
         assign st_vld = vld_w[k-1];
         assign st_sum = sum_w[k-1];
         assign st_ovf = ovf_w[k-1];
         assign st_a   = g_stage[k-1].g_carry.ca_q[AW-1:0];
         assign st_b   = g_stage[k-1].g_carry.cb_q[N*AW-1:0];
      end

      // Operand rows k+1..K-1 still needed by later stages, row k+1 lowest.
      // Not reset: contents are only meaningful under a valid bit.
      if (k < K-1) begin : g_carry
         logic [(K-1-k)*AW-1:0]   ca_q;
         logic [(K-1-k)*N*AW-1:0] cb_q;
         if (k == 0) begin : g_src_in
            always_ff @(posedge clk) begin
               if (adv) begin
                  ca_q <= a[K-1:1];
                  cb_q <= b[K-1:1];
               end
            end
         end else begin : g_src_prev
            always_ff @(posedge clk) begin
               if (adv) begin
                  ca_q <= g_stage[k-1].g_carry.ca_q[(K-k)*AW-1:AW];
                  cb_q <= g_stage[k-1].g_carry.cb_q[(K-k)*N*AW-1:N*AW];
               end
            end
         end
      end

      tmul_fma_stage #(
         .AW (AW),
         .N  (N),
         .CW (CW)
      ) u_fma (
         .clk   (clk),
         .rst   (rst),
         .en_i  (adv),
         .vld_i (st_vld),
         .sum_i (st_sum),
         .ovf_i (st_ovf),
         .a_i   (st_a),
         .b_i   (st_b),
         .vld_o (vld_w[k]),
         .sum_o (sum_w[k]),
         .ovf_o (ovf_w[k])
      );
   end

   assign out_valid = vld_w[K-1];
   assign c         = sum_w[K-1];
   assign ovf       = ovf_w[K-1];
   assign busy      = |vld_w;

endmodule

// File: tb/tb_tmul_kxn_pipe.sv
// -----------------------------------------------------------------------------
// tb_tmul_kxn_pipe
// Directed and randomized stimulus for tmul_kxn_pipe at default parameters.
// A reference model computes each accepted tile's columns with wide plain
// arithmetic (seed plus K products, wrap at 2^CW, flag any wrap) and queues the
// expected result; the monitor compares every taken result in order, checks
// latency, hold-during-stall, in_ready and busy.
// -----------------------------------------------------------------------------
module tb_tmul_kxn_pipe;
   import tmul_pkg::*;

   localparam int AW = TMUL_AW;
   localparam int K  = TMUL_K;
   localparam int N  = TMUL_N;
   localparam int CW = TMUL_CW;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   in_valid;
   logic                   in_ready;
   logic [K-1:0][AW-1:0]   a;
   logic [K-1:0][N*AW-1:0] b;
   logic [N-1:0][CW-1:0]   c_in;
   logic                   acc_en;
   logic                   out_valid;
   logic                   out_ready;
   logic [N-1:0][CW-1:0]   c;
   logic [N-1:0]           ovf;
   logic                   busy;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int last_low = -1;

   logic [N-1:0][CW-1:0] exp_c_q[$];
   logic [N-1:0]         exp_o_q[$];
   int                   exp_t_q[$];

   logic                 held = 1'b0;
   logic [N-1:0][CW-1:0] prev_c;
   logic [N-1:0]         prev_ovf;
   logic [N-1:0][CW-1:0] last_c;
   logic [N-1:0]         last_ovf;
   logic                 rnd_done;

   tmul_kxn_pipe #(
      .AW (AW),
      .K  (K),
      .N  (N),
      .CW (CW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .c_in      (c_in),
      .acc_en    (acc_en),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .c         (c),
      .ovf       (ovf),
      .busy      (busy)
   );

   // ---------------- clock / reset ----------------
   initial forever #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1, "watchdog");
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   task automatic model_push();
      logic [N-1:0][CW-1:0] r;
      logic [N-1:0]         o;
      logic [127:0]         acc;
      logic [127:0]         two_cw;
      logic [127:0]         pa;
      logic [127:0]         pb;
      two_cw = 128'd1 << CW;
      for (int n = 0; n < N; n++) begin
         acc  = acc_en ? 128'(c_in[n]) : 128'd0;
         o[n] = 1'b0;
         for (int k = 0; k < K; k++) begin
            pa  = 128'(a[k]);
            pb  = 128'(b[k][n*AW +: AW]);
            acc = acc + pa * pb;
            if (acc >= two_cw) begin
               o[n] = 1'b1;
               acc  = acc - two_cw;
            end
         end
         r[n] = acc[CW-1:0];
      end
      exp_c_q.push_back(r);
      exp_o_q.push_back(o);
      exp_t_q.push_back(cyc);
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      logic [N-1:0][CW-1:0] ec;
      logic [N-1:0]         eo;
      int                   t;
      int                   lat;
      if (rst) begin
         check("rst_in_ready", CW'(in_ready), '0);
         exp_c_q.delete();
         exp_o_q.delete();
         exp_t_q.delete();
         held = 1'b0;
      end else begin
         check("in_ready", CW'(in_ready), CW'(!(out_valid && !out_ready)));
         check("busy", CW'(busy), CW'(exp_c_q.size() != 0));
         if (held) begin
            check("hold_valid", CW'(out_valid), CW'(1));
            for (int n = 0; n < N; n++) check("hold_c", c[n], prev_c[n]);
            check("hold_ovf", CW'(ovf), CW'(prev_ovf));
         end
         if (!out_ready) last_low = cyc;
         if (in_valid && in_ready) model_push();
         if (out_valid && out_ready) begin
            if (exp_c_q.size() == 0) begin
               check("spurious_out", CW'(out_valid), '0);
            end else begin
               ec  = exp_c_q.pop_front();
               eo  = exp_o_q.pop_front();
               t   = exp_t_q.pop_front();
               lat = cyc - t;
               for (int n = 0; n < N; n++) check("c", c[n], ec[n]);
               check("ovf", CW'(ovf), CW'(eo));
               if (last_low >= t) check("latency_min", CW'(lat >= K), CW'(1));
               else               check("latency", CW'(lat), CW'(K));
               last_c   = c;
               last_ovf = ovf;
            end
         end
         held     = out_valid && !out_ready;
         prev_c   = c;
         prev_ovf = ovf;
      end
   end

   // ---------------- driver tasks ----------------
   // Present the tile currently on a/b/c_in/acc_en until it is accepted.
   task automatic send_tile();
      int guard;
      guard    = 0;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      check("accept_wait", CW'(guard >= 100), '0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 300 && exp_c_q.size() != 0; i++) @(negedge clk);
      check("drain", CW'(exp_c_q.size()), '0);
      @(posedge clk);
      #1;
   endtask

   task automatic set_basic_tile();
      a = '0;
      b = '0;
      for (int k = 0; k < K; k++) begin
         a[k] = AW'(1);
         for (int n = 0; n < N; n++) b[k][n*AW +: AW] = AW'(n + 1);
      end
   endtask

   task automatic set_stream_tile(input int t);
      for (int k = 0; k < K; k++) begin
         a[k] = AW'(t);
         for (int n = 0; n < N; n++) b[k][n*AW +: AW] = AW'(1);
      end
      acc_en = 1'b0;
   endtask

   task automatic set_random_tile();
      for (int k = 0; k < K; k++) begin
         a[k] = ($urandom_range(0, 3) == 0) ? '1 : AW'($urandom);
         for (int n = 0; n < N; n++) b[k][n*AW +: AW] = AW'($urandom);
      end
      for (int n = 0; n < N; n++) c_in[n] = {$urandom, $urandom};
      acc_en = 1'($urandom_range(0, 1));
   endtask

   // ---------------- main sequence ----------------
   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; acc_en = 1'b0;
      a = '0; b = '0; c_in = '0; rnd_done = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", CW'(out_valid), '0);
      check("rst_busy", CW'(busy), '0);
      check("rst_ovf", CW'(ovf), '0);
      for (int n = 0; n < N; n++) check("rst_c", c[n], '0);
      rst = 1'b0;

      // Single tile, no accumulate.
      set_basic_tile();
      acc_en = 1'b0;
      send_tile();
      drain();
      for (int n = 0; n < N; n++) check("single_c", last_c[n], CW'(8 * (n + 1)));
      check("single_ovf", CW'(last_ovf), '0);

      // Same tile seeded from c_in.
      set_basic_tile();
      acc_en = 1'b1;
      for (int n = 0; n < N; n++) c_in[n] = CW'(100);
      send_tile();
      drain();
      for (int n = 0; n < N; n++) check("accum_c", last_c[n], CW'(100 + 8 * (n + 1)));

      // Back-to-back streaming of 20 tiles.
      for (int t = 0; t < 20; t++) begin
         set_stream_tile(t);
         send_tile();
      end
      drain();
      for (int n = 0; n < N; n++) check("stream_last_c", last_c[n], CW'(8 * 19));

      // Streaming with 5 cycles of backpressure in the middle.
      fork
         begin
            for (int t = 0; t < 20; t++) begin
               set_stream_tile(t + 1);
               send_tile();
            end
         end
         begin
            repeat (12) @(posedge clk);
            #1;
            out_ready = 1'b0;
            repeat (5) begin
               @(negedge clk);
               check("bp_in_ready", CW'(in_ready), '0);
               check("bp_out_valid", CW'(out_valid), CW'(1));
            end
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      drain();
      for (int n = 0; n < N; n++) check("bp_last_c", last_c[n], CW'(8 * 20));

      // Carry-out of column 0 only.
      a = '0; b = '0; c_in = '0;
      acc_en     = 1'b1;
      c_in[0]    = '1;
      a[0]       = AW'(1);
      b[0][AW-1:0] = AW'(1);
      send_tile();
      drain();
      check("ovf_c0", last_c[0], '0);
      check("ovf_flags", CW'(last_ovf), CW'(1));

      // Reset with 4 tiles in flight.
      for (int t = 0; t < 4; t++) begin
         set_random_tile();
         send_tile();
      end
      check("pre_rst_busy", CW'(busy), CW'(1));
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("post_rst_out_valid", CW'(out_valid), '0);
      check("post_rst_busy", CW'(busy), '0);
      repeat (20) @(negedge clk);
      check("post_rst_quiet", CW'(out_valid), '0);
      @(posedge clk);
      #1;

      // Randomized tiles, bubbles and backpressure.
      fork
         begin
            for (int t = 0; t < 60; t++) begin
               int gap;
               set_random_tile();
               send_tile();
               gap = $urandom_range(0, 2);
               for (int g = 0; g < gap; g++) begin
                  @(posedge clk);
                  #1;
               end
            end
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               @(posedge clk);
               #1;
               out_ready = ($urandom_range(0, 3) != 0);
            end
            out_ready = 1'b1;
         end
      join
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
